// File: rtl/spu32_cpu_div.sv
// spu32_cpu_div -- multi-cycle 32-bit integer divider for the SPU32 ALU.
//
// Handles DIV, DIVU, REM and REMU with a restoring shift-subtract loop that
// retires one quotient bit per cycle. Signed operations divide magnitudes and
// then correct the signs.
//
// Ports:
//   I_clk    : clock, all state changes on the rising edge
//   I_reset  : asynchronous active-high reset
//   I_en     : operation enable from the ALU
//   I_op     : 4-bit ALU opcode (only the four divide opcodes start work)
//   I_s1     : dividend
//   I_s2     : divisor
//   O_result : quotient or remainder, held until the next completion/reset
//   O_busy   : combinational stall request to the pipeline
//
// Optional feature: define SPU32_DIV_FASTPATH_EN to resolve divide-by-zero
// and signed overflow in the request cycle, skipping the iterative loop.

module spu32_cpu_div (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_en,
    input  logic [3:0]  I_op,
    input  logic [31:0] I_s1,
    input  logic [31:0] I_s2,
    output logic [31:0] O_result,
    output logic        O_busy
);

    // Shared ALU opcode encodings for the divide group.
    localparam logic [3:0] ALUOP_DIV  = 4'b1100;
    localparam logic [3:0] ALUOP_DIVU = 4'b1101;
    localparam logic [3:0] ALUOP_REM  = 4'b1110;
    localparam logic [3:0] ALUOP_REMU = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvsr_q;
    logic        rem_op_q;
    logic        qneg_q;
    logic        s1neg_q;
    logic        dz_q;
    logic        ovf_q;
    logic [31:0] result_q;

    // Request decode
    logic        in_div_op;
    logic        in_signed;
    logic        in_rem_op;
    logic        in_s1_neg;
    logic        in_s2_neg;
    logic [31:0] in_abs1;
    logic [31:0] in_abs2;
    logic        in_dz;
    logic        in_ovf;
    logic        start;

    always_comb begin
        in_div_op = (I_op == ALUOP_DIV) || (I_op == ALUOP_DIVU) ||
                    (I_op == ALUOP_REM) || (I_op == ALUOP_REMU);
        in_signed = (I_op == ALUOP_DIV) || (I_op == ALUOP_REM);
        in_rem_op = (I_op == ALUOP_REM) || (I_op == ALUOP_REMU);
        in_s1_neg = in_signed && I_s1[31];
        in_s2_neg = in_signed && I_s2[31];
        // 32-bit wrap: the magnitude of 0x80000000 stays 0x80000000 (unsigned)
        in_abs1   = in_s1_neg ? (32'd0 - I_s1) : I_s1;
        in_abs2   = in_s2_neg ? (32'd0 - I_s2) : I_s2;
        in_dz     = (I_s2 == '0);
        in_ovf    = in_signed && (I_s1 == 32'h8000_0000) && (I_s2 == '1);
        start     = I_en && in_div_op;
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract the divisor and keep the difference if non-negative.
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic [31:0] rem_d;
    logic [31:0] quo_d;

    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        diff      = rem_shift - {1'b0, dvsr_q};
        if (!diff[32]) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
        end else begin
            rem_d = rem_shift[31:0];
            quo_d = {quo_q[30:0], 1'b0};
        end
    end

    // Sign correction and special-case substitution.
    // For divide-by-zero the loop already leaves |dividend| in the remainder,
    // so the dividend-signed correction reproduces the original dividend.
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] fix_result;

    always_comb begin
        q_fix = qneg_q  ? (32'd0 - quo_q) : quo_q;
        r_fix = s1neg_q ? (32'd0 - rem_q) : rem_q;
        if (dz_q) begin
            q_fix = '1;
        end else if (ovf_q) begin
            q_fix = 32'h8000_0000;
            r_fix = '0;
        end
        fix_result = rem_op_q ? r_fix : q_fix;
    end

`ifdef SPU32_DIV_FASTPATH_EN
    logic [31:0] fast_result;

    always_comb begin
        if (in_dz) begin
            fast_result = in_rem_op ? I_s1 : '1;
        end else begin
            fast_result = in_rem_op ? '0 : 32'h8000_0000;
        end
    end
`endif

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            rem_op_q <= 1'b0;
            qneg_q   <= 1'b0;
            s1neg_q  <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        quo_q    <= in_abs1;
                        rem_q    <= '0;
                        dvsr_q   <= in_abs2;
                        cnt_q    <= '0;
                        rem_op_q <= in_rem_op;
                        qneg_q   <= in_s1_neg ^ in_s2_neg;
                        s1neg_q  <= in_s1_neg;
                        dz_q     <= in_dz;
                        ovf_q    <= in_ovf;
`ifdef SPU32_DIV_FASTPATH_EN
                        if (in_dz || in_ovf) begin
                            result_q <= fast_result;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= RUN;
                        end
`else
                        state_q  <= RUN;
`endif
                    end
                end
                RUN: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q <= fix_result;
                    state_q  <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign O_busy   = ((state_q == IDLE) && start) || (state_q == RUN) || (state_q == FIX);
    assign O_result = result_q;

endmodule

// File: tb/tb_spu32_cpu_div.sv
// tb_spu32_cpu_div -- self-checking bench for spu32_cpu_div.
// Directed vectors plus randomized operations, checked against a plain
// arithmetic reference model; follows SPU32_DIV_FASTPATH_EN for latency.

module tb_spu32_cpu_div;

    localparam logic [3:0] ALUOP_ADD  = 4'b0000;
    localparam logic [3:0] ALUOP_DIV  = 4'b1100;
    localparam logic [3:0] ALUOP_DIVU = 4'b1101;
    localparam logic [3:0] ALUOP_REM  = 4'b1110;
    localparam logic [3:0] ALUOP_REMU = 4'b1111;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] result;
    logic        busy;

    int unsigned checks;
    int unsigned errors;
    logic [31:0] last_result;

    spu32_cpu_div dut (
        .I_clk    (clk),
        .I_reset  (rst),
        .I_en     (en),
        .I_op     (op),
        .I_s1     (s1),
        .I_s2     (s2),
        .O_result (result),
        .O_busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic is_signed_op(input logic [3:0] o);
        return (o == ALUOP_DIV) || (o == ALUOP_REM);
    endfunction

    function automatic logic is_special(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (is_signed_op(o) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Reference: language-level division with the architectural special cases.
    function automatic logic [31:0] ref_div(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic is_rem;
        is_rem = (o == ALUOP_REM) || (o == ALUOP_REMU);
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        if (is_signed_op(o)) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return is_rem ? 32'd0 : 32'h8000_0000;
            return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end
        return is_rem ? (a % b) : (a / b);
    endfunction

    // Issue one request at the next negedge (cycle T) and follow it to DONE.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp;
        int unsigned lat;
        exp = ref_div(o, a, b);
        lat = 34;
`ifdef SPU32_DIV_FASTPATH_EN
        if (is_special(o, a, b)) lat = 1;
`endif
        @(negedge clk);
        en = 1'b1; op = o; s1 = a; s2 = b;
        #1 chk({tag, "_busyT"}, 32'(busy), 32'd1);
        for (int unsigned k = 1; k <= lat; k++) begin
            @(negedge clk);
            #1;
            chk({tag, "_busy"}, 32'(busy), (k < lat) ? 32'd1 : 32'd0);
            if (k == 1) begin
                // operands may wander once captured
                s1 = $urandom;
                s2 = $urandom;
            end
            if (k == lat) chk({tag, "_result"}, result, exp);
        end
        last_result = exp;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            en = 1'b0; op = ALUOP_ADD;
        end
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0;
        errors = 0;
        rst = 1'b1; en = 1'b0; op = ALUOP_ADD; s1 = '0; s2 = '0;
        last_result = '0;

        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(ALUOP_DIV,  32'hFFFF_FFF9, 32'd2,  "div_m7_2");
        run_op(ALUOP_REM,  32'hFFFF_FFF9, 32'd2,  "rem_m7_2");
        idle(1);
        run_op(ALUOP_DIVU, 32'hFFFF_FFFF, 32'h10, "divu_ff_10");
        run_op(ALUOP_REMU, 32'hFFFF_FFFF, 32'h10, "remu_ff_10");
        run_op(ALUOP_DIV,  32'd5, 32'd0, "div_5_0");
        run_op(ALUOP_REM,  32'd5, 32'd0, "rem_5_0");
        run_op(ALUOP_DIVU, 32'd5, 32'd0, "divu_5_0");
        run_op(ALUOP_DIV,  32'hFFFF_FFFB, 32'd0, "div_m5_0");
        run_op(ALUOP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(ALUOP_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(ALUOP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
        idle(2);

        // Reset in the middle of a running operation
        @(negedge clk);
        en = 1'b1; op = ALUOP_DIVU; s1 = 32'd100; s2 = 32'd7;
        #1 chk("rst_mid_busyT", 32'(busy), 32'd1);
        repeat (10) @(negedge clk);
        #1;
        rst = 1'b1; en = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_result", result, 32'd0);
        @(negedge clk);
        #1 chk("rst_hold_result", result, 32'd0);
        rst = 1'b0;
        run_op(ALUOP_DIVU, 32'd100, 32'd7, "divu_after_rst");

        // Back-to-back issue in the cycle after DONE
        idle(1);
        run_op(ALUOP_REMU, 32'd100, 32'd7, "b2b_remu");
        run_op(ALUOP_DIV,  32'hFFFF_FF9C, 32'd7, "b2b_div");

        // Non-divide opcode with enable high
        @(negedge clk);
        en = 1'b1; op = ALUOP_ADD; s1 = 32'd3; s2 = 32'd4;
        #1 chk("add_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("add_busy_later", 32'(busy), 32'd0);
        chk("add_result_held", result, last_result);

        // Randomized operations
        for (int unsigned n = 0; n < 24; n++) begin
            rop = 4'(32'(ALUOP_DIV) + $urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 1) == 0) idle(1);
            run_op(rop, ra, rb, "rand");
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
